// File: rtl/video_pkg.sv
// Shared video-timing constants and the CPU clock-gate FSM encoding.
package video_pkg;

  localparam int HDISP    = 256;
  localparam int VDISP    = 192;
  localparam int MAXSTALL = 7;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } gate_state_e;

endpackage

// File: rtl/contention_window.sv
// Combinational decode of the display window where the ULA owns the bus.
module contention_window #(
  parameter int HDISP = video_pkg::HDISP,
  parameter int VDISP = video_pkg::VDISP
) (
  input  logic [8:0] hc_i,
  input  logic [8:0] vc_i,
  output logic       window_o
);

  localparam logic [9:0] HDISP_W = 10'(HDISP);
  localparam logic [9:0] VDISP_W = 10'(VDISP);

  // T-state slots 6 and 7 of each 16-pixel group leave the bus free.
  assign window_o = ({1'b0, vc_i} < VDISP_W) &
                    ({1'b0, hc_i} < HDISP_W) &
                    ~(hc_i[3] & hc_i[2]);

endmodule

// File: rtl/cpu_clock_gate.sv
// Gated CPU clock: stretches the low phase while contended accesses hit the display window.
module cpu_clock_gate
  import video_pkg::*;
#(
  parameter int HDISP    = video_pkg::HDISP,
  parameter int VDISP    = video_pkg::VDISP,
  parameter int MAXSTALL = video_pkg::MAXSTALL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pe3M5,
  input  logic       ne3M5,
  input  logic [8:0] hc,
  input  logic [8:0] vc,
  input  logic       contend,
  output logic       cpuPe,
  output logic       cpuNe,
  output logic       cpuClock,
  output logic       stalled,
  output logic [3:0] stallCount
);

  localparam logic [3:0] MAX_CNT = 4'(MAXSTALL);

  gate_state_e state_q, state_d;
  logic        cpu_pe_q, cpu_pe_d;
  logic        cpu_ne_q, cpu_ne_d;
  logic        cpu_clock_q, cpu_clock_d;
  logic [3:0]  stall_cnt_q, stall_cnt_d;

  logic window;
  logic pe_evt;
  logic hold_req;

  contention_window #(
    .HDISP (HDISP),
    .VDISP (VDISP)
  ) u_window (
    .hc_i     (hc),
    .vc_i     (vc),
    .window_o (window)
  );

  // Simultaneous strobes are illegal; the falling edge wins.
  assign pe_evt   = pe3M5 & ~ne3M5;
  assign hold_req = contend & window;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d     = state_q;
    cpu_pe_d    = 1'b0;
    cpu_ne_d    = 1'b0;
    cpu_clock_d = cpu_clock_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (cpu_clock_q) begin
          if (ne3M5) begin
            cpu_ne_d    = 1'b1;
            cpu_clock_d = 1'b0;
          end
        end else if (pe_evt) begin
          if (hold_req) begin
            state_d     = HOLD;
            stall_cnt_d = 4'd1;
          end else begin
            cpu_pe_d    = 1'b1;
            cpu_clock_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // The clock is low in HOLD, so falling-edge strobes have nothing to do here.
        if (pe_evt) begin
          if (hold_req && (stall_cnt_q < MAX_CNT)) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
          end else begin
            state_d     = RUN;
            cpu_pe_d    = 1'b1;
            cpu_clock_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      cpu_pe_q    <= 1'b0;
      cpu_ne_q    <= 1'b0;
      cpu_clock_q <= 1'b0;
      stall_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      cpu_pe_q    <= cpu_pe_d;
      cpu_ne_q    <= cpu_ne_d;
      cpu_clock_q <= cpu_clock_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cpuPe      = cpu_pe_q;
  assign cpuNe      = cpu_ne_q;
  assign cpuClock   = cpu_clock_q;
  assign stalled    = (state_q == HOLD);
  assign stallCount = stall_cnt_q;

endmodule
